// File: rtl/i2c_seq_pkg.sv
// Shared types for the I2C transaction sequencer: FSM state encoding and the queued command word.
package i2c_seq_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LAUNCH,
        S_WAIT,
        S_RESP
    } seq_state_t;

    typedef struct packed {
        logic [6:0] addr;
        logic       rw;
        logic [7:0] wdata;
    } i2c_cmd_t;

endpackage

// File: rtl/i2c_cmd_fifo.sv
// Command queue between the host handshake and the sequencer FSM; head visible one cycle after push, no bypass.
// Pushes are refused while full; a same-cycle pop frees a slot only from the next cycle on.
module i2c_cmd_fifo
    import i2c_seq_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic     clk,
    input  logic     rst_n,
    input  logic     push,
    input  i2c_cmd_t wr_dat,
    input  logic     pop,
    output i2c_cmd_t rd_dat,
    output logic     full,
    output logic     empty
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);

    i2c_cmd_t      mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == CNT_FULL);
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rd_dat  = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wr_dat;
    end

endmodule

// File: rtl/i2c_txn_sequencer.sv
// Queues I2C commands, runs them one at a time on the engine by dropping eng_rst, returns one in-order response each.
// Command reaches the engine two cycles after an idle push; a response holds until rsp_ready, cmd_ready = FIFO not full.
module i2c_txn_sequencer
    import i2c_seq_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 64
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [6:0] cmd_addr,
    input  logic       cmd_rw,
    input  logic [7:0] cmd_wdata,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic [7:0] rsp_rdata,
    output logic       rsp_rw,
    output logic       rsp_timeout,
    output logic       eng_rst,
    output logic [6:0] eng_addr,
    output logic       eng_rw,
    output logic [7:0] eng_wdata,
    input  logic [7:0] eng_rdata,
    input  logic       eng_done,
    output logic       busy
);
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);

    seq_state_t    state;
    seq_state_t    state_nxt;
    i2c_cmd_t      cmd_in;
    i2c_cmd_t      head;
    logic          fifo_full;
    logic          fifo_empty;
    logic          pop;
    logic          timer_clr;
    logic          timer_inc;
    logic          done_hit;
    logic          to_hit;
    logic          rsp_take;
    logic [TW-1:0] timer;

    assign cmd_in    = '{addr: cmd_addr, rw: cmd_rw, wdata: cmd_wdata};
    assign cmd_ready = !fifo_full;
    assign busy      = (state != S_IDLE) || !fifo_empty;

    i2c_cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk    (clk),
        .rst_n  (rst_n),
        .push   (cmd_valid),
        .wr_dat (cmd_in),
        .pop    (pop),
        .rd_dat (head),
        .full   (fifo_full),
        .empty  (fifo_empty)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   if (!fifo_empty) state_nxt = S_LAUNCH;
            S_LAUNCH: state_nxt = S_WAIT;
            S_WAIT:   if (eng_done || (timer == T_LAST)) state_nxt = S_RESP;
            S_RESP:   if (rsp_ready) state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    // A completion in the final timer cycle still counts as a completion.
    always_comb begin
        pop       = 1'b0;
        timer_clr = 1'b0;
        timer_inc = 1'b0;
        done_hit  = 1'b0;
        to_hit    = 1'b0;
        rsp_take  = 1'b0;
        case (state)
            S_IDLE:   pop       = !fifo_empty;
            S_LAUNCH: timer_clr = 1'b1;
            S_WAIT: begin
                timer_inc = (timer != '1);
                done_hit  = eng_done;
                to_hit    = !eng_done && (timer == T_LAST);
            end
            S_RESP:   rsp_take  = rsp_ready;
            default:  pop       = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            eng_rst     <= 1'b1;
            eng_addr    <= '0;
            eng_rw      <= 1'b0;
            eng_wdata   <= '0;
            timer       <= '0;
            rsp_valid   <= 1'b0;
            rsp_rdata   <= '0;
            rsp_rw      <= 1'b0;
            rsp_timeout <= 1'b0;
        end else begin
            // Engine is released on the same edge the head is loaded, so it is low throughout S_LAUNCH.
            if (pop) begin
                eng_addr  <= head.addr;
                eng_rw    <= head.rw;
                eng_wdata <= head.wdata;
                eng_rst   <= 1'b0;
            end
            if (timer_clr)      timer <= '0;
            else if (timer_inc) timer <= timer + 1'b1;
            if (done_hit || to_hit) begin
                eng_rst     <= 1'b1;
                rsp_valid   <= 1'b1;
                rsp_rw      <= eng_rw;
                rsp_timeout <= to_hit;
                rsp_rdata   <= (done_hit && !eng_rw) ? eng_rdata : 8'h00;
            end
            if (rsp_take) rsp_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_i2c_txn_sequencer.sv
// Directed bench for i2c_txn_sequencer: behavioural slave engine, timestamp-based reference model, per-cycle compare.
module tb_i2c_txn_sequencer;
    import i2c_seq_pkg::*;

    localparam int DEPTH   = 4;
    localparam int TIMEOUT = 64;
    localparam int NEVER   = 0;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [6:0] cmd_addr = '0;
    logic       cmd_rw = 1'b0;
    logic [7:0] cmd_wdata = '0;
    logic       rsp_valid;
    logic       rsp_ready = 1'b0;
    logic [7:0] rsp_rdata;
    logic       rsp_rw;
    logic       rsp_timeout;
    logic       eng_rst;
    logic [6:0] eng_addr;
    logic       eng_rw;
    logic [7:0] eng_wdata;
    logic [7:0] eng_rdata = 8'h5A;
    logic       eng_done = 1'b0;
    logic       busy;
    int         cur_lat = 0;

    always #5 clk = ~clk;

    i2c_txn_sequencer #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_addr(cmd_addr), .cmd_rw(cmd_rw), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_rw(rsp_rw), .rsp_timeout(rsp_timeout),
        .eng_rst(eng_rst), .eng_addr(eng_addr), .eng_rw(eng_rw), .eng_wdata(eng_wdata),
        .eng_rdata(eng_rdata), .eng_done(eng_done), .busy(busy)
    );

    int n_cmp = 0;
    int n_bad = 0;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endfunction

    function automatic logic [7:0] init_val(int i);
        return 8'(i * 3 + 1);
    endfunction

    // Slave engine: done is sampled by the DUT exactly 'lat' edges after the release edge.
    int         e_lat_q[$];
    int         e_cnt;
    int         e_lat;
    logic [7:0] e_mem [128];
    initial forever begin
        @(negedge clk or negedge rst_n);
        if (!rst_n) begin
            e_lat_q.delete();
            e_cnt = 0;
            eng_done = 1'b0;
            eng_rdata = 8'h5A;
            for (int i = 0; i < 128; i++) e_mem[i] = init_val(i);
        end else begin
            if (eng_rst) begin
                e_cnt = 0;
                eng_done = 1'b0;
                eng_rdata = 8'h5A;
            end else begin
                if (e_cnt == 0) e_lat = (e_lat_q.size() > 0) ? e_lat_q.pop_front() : NEVER;
                e_cnt++;
                eng_done = (e_lat != NEVER) && (e_cnt == e_lat);
                eng_rdata = 8'h5A;
                if (eng_done) begin
                    if (eng_rw) begin
                        e_mem[eng_addr] = eng_wdata;
                        eng_rdata = 8'hEE;
                    end else begin
                        eng_rdata = e_mem[eng_addr];
                    end
                end
            end
            if (cmd_valid && cmd_ready) e_lat_q.push_back(cur_lat);
        end
    end

    // Reference model: a command launches one edge after both "queued" and "sequencer free";
    // its response appears at launch+lat, or at launch+TIMEOUT+1 if the engine is slower.
    typedef struct {
        logic [6:0] addr;
        logic       rw;
        logic [7:0] wdata;
        int         lat;
    } mcmd_t;

    mcmd_t      m_fifo[$];
    mcmd_t      m_cur;
    int         m_phase = 0;  // 0 free, 1 engine running, 2 response pending
    int         m_due;
    int         cyc = 0;
    logic       m_push;
    logic       m_to_x;
    logic       m_rw_x;
    logic [7:0] m_rd_x;
    logic [7:0] m_mem [128];

    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            m_fifo.delete();
            m_phase = 0;
            for (int i = 0; i < 128; i++) m_mem[i] = init_val(i);
        end else begin
            cyc++;
            m_push = cmd_valid && (m_fifo.size() < DEPTH);
            if (m_phase == 0) begin
                if (m_fifo.size() > 0) begin
                    m_cur = m_fifo.pop_front();
                    m_to_x = (m_cur.lat == NEVER) || (m_cur.lat > TIMEOUT + 1);
                    m_due = cyc + (m_to_x ? TIMEOUT + 1 : m_cur.lat);
                    m_phase = 1;
                end
            end else if (m_phase == 1) begin
                if (cyc == m_due) begin
                    m_rw_x = m_cur.rw;
                    m_rd_x = (m_to_x || m_cur.rw) ? 8'h00 : m_mem[m_cur.addr];
                    if (!m_to_x && m_cur.rw) m_mem[m_cur.addr] = m_cur.wdata;
                    m_phase = 2;
                end
            end else if (rsp_ready) begin
                m_phase = 0;
            end
            if (m_push) m_fifo.push_back('{addr: cmd_addr, rw: cmd_rw, wdata: cmd_wdata, lat: cur_lat});
        end
    end

    // Per-cycle compare plus a log of accepted responses for the literal checks.
    logic       chk_en = 1'b0;
    logic       prev_rst = 1'b1;
    logic       prev_vld = 1'b0;
    int         launch_cyc = 0;
    int         rise_cyc = 0;
    logic [7:0] log_rdata[$];
    logic       log_rw[$];
    logic       log_to[$];
    int         log_wait[$];

    initial forever begin
        @(negedge clk);
        if (rst_n) begin
            if (chk_en) begin
                chk("cmd_ready", cmd_ready, m_fifo.size() < DEPTH);
                chk("busy", busy, (m_fifo.size() != 0) || (m_phase != 0));
                chk("eng_rst", eng_rst, m_phase != 1);
                chk("rsp_valid", rsp_valid, m_phase == 2);
                if (m_phase == 1) begin
                    chk("eng_addr", eng_addr, m_cur.addr);
                    chk("eng_rw", eng_rw, m_cur.rw);
                    chk("eng_wdata", eng_wdata, m_cur.wdata);
                end
                if (m_phase == 2) begin
                    chk("rsp_rw", rsp_rw, m_rw_x);
                    chk("rsp_rdata", rsp_rdata, m_rd_x);
                    chk("rsp_timeout", rsp_timeout, m_to_x);
                end
            end
            if (prev_rst && !eng_rst) launch_cyc = cyc;
            if (rsp_valid && !prev_vld) rise_cyc = cyc;
            if (rsp_valid && rsp_ready) begin
                log_rdata.push_back(rsp_rdata);
                log_rw.push_back(rsp_rw);
                log_to.push_back(rsp_timeout);
                log_wait.push_back(rise_cyc - launch_cyc - 1);
            end
            prev_rst = eng_rst;
            prev_vld = rsp_valid;
        end else begin
            prev_rst = 1'b1;
            prev_vld = 1'b0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_cmd(input logic [6:0] a, input logic r, input logic [7:0] d, input int lat);
        logic acc;
        acc = 1'b0;
        cmd_addr = a;
        cmd_rw = r;
        cmd_wdata = d;
        cur_lat = lat;
        cmd_valid = 1'b1;
        for (int i = 0; i < 500 && !acc; i++) begin
            @(negedge clk);
            acc = cmd_ready;
            tick();
        end
        cmd_valid = 1'b0;
        if (!acc) chk("push_accept", acc, 1'b1);
    endtask

    task automatic wait_idle(input int max_cyc);
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < max_cyc && !ok; i++) begin
            @(negedge clk);
            ok = !busy && !rsp_valid && (m_phase == 0) && (m_fifo.size() == 0);
        end
        chk("idle_wait", ok, 1'b1);
        tick();
    endtask

    int   base;
    logic seen;

    initial begin
        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_cmd_ready", cmd_ready, 1'b1);
        chk("rst_rsp_valid", rsp_valid, 1'b0);
        chk("rst_rsp_rdata", rsp_rdata, 8'h00);
        chk("rst_rsp_rw", rsp_rw, 1'b0);
        chk("rst_rsp_timeout", rsp_timeout, 1'b0);
        chk("rst_eng_rst", eng_rst, 1'b1);
        chk("rst_eng_addr", eng_addr, 7'h00);
        chk("rst_eng_rw", eng_rw, 1'b0);
        chk("rst_eng_wdata", eng_wdata, 8'h00);
        chk("rst_busy", busy, 1'b0);
        rst_n = 1'b1;
        rsp_ready = 1'b1;
        chk_en = 1'b1;
        tick();

        // Single write.
        base = log_rdata.size();
        push_cmd(7'h2A, 1'b1, 8'hA5, 21);
        wait_idle(200);
        chk("t1_nrsp", log_rdata.size() - base, 1);
        chk("t1_rw", log_rw[base], 1'b1);
        chk("t1_rdata", log_rdata[base], 8'h00);
        chk("t1_timeout", log_to[base], 1'b0);
        chk("t1_slave_mem", e_mem[7'h2A], 8'hA5);

        // Write then read back, back-to-back.
        base = log_rdata.size();
        push_cmd(7'h10, 1'b1, 8'h3C, 21);
        push_cmd(7'h10, 1'b0, 8'h00, 9);
        wait_idle(300);
        chk("t2_nrsp", log_rdata.size() - base, 2);
        chk("t2_first_rw", log_rw[base], 1'b1);
        chk("t2_second_rw", log_rw[base+1], 1'b0);
        chk("t2_second_rdata", log_rdata[base+1], 8'h3C);

        // Fill: the first command goes straight to the engine, the next four fill the FIFO.
        rsp_ready = 1'b0;
        base = log_rdata.size();
        push_cmd(7'h01, 1'b1, 8'h11, 5);
        push_cmd(7'h02, 1'b1, 8'h22, 3);
        push_cmd(7'h01, 1'b0, 8'h00, 4);
        push_cmd(7'h02, 1'b0, 8'h00, 7);
        chk("t3_ready_before_full", cmd_ready, 1'b1);
        push_cmd(7'h03, 1'b0, 8'h00, 2);
        chk("t3_full", cmd_ready, 1'b0);
        repeat (20) tick();
        chk("t3_rsp_held", rsp_valid, 1'b1);
        rsp_ready = 1'b1;
        wait_idle(500);
        chk("t3_nrsp", log_rdata.size() - base, 5);
        chk("t3_rdata2", log_rdata[base+2], 8'h11);
        chk("t3_rdata3", log_rdata[base+3], 8'h22);
        chk("t3_rdata4", log_rdata[base+4], 8'h0A);

        // Engine never completes.
        base = log_rdata.size();
        push_cmd(7'h20, 1'b0, 8'h00, NEVER);
        wait_idle(300);
        chk("t4_timeout", log_to[base], 1'b1);
        chk("t4_rdata", log_rdata[base], 8'h00);
        chk("t4_wait_cycles", log_wait[base], TIMEOUT);
        chk("t4_eng_rst", eng_rst, 1'b1);

        // Completion in the last timer cycle wins; one cycle later it is a timeout.
        base = log_rdata.size();
        push_cmd(7'h2A, 1'b0, 8'h00, TIMEOUT + 1);
        push_cmd(7'h2A, 1'b0, 8'h00, TIMEOUT + 2);
        wait_idle(400);
        chk("t5_tie_timeout", log_to[base], 1'b0);
        chk("t5_tie_rdata", log_rdata[base], 8'hA5);
        chk("t5_tie_wait", log_wait[base], TIMEOUT);
        chk("t5_late_timeout", log_to[base+1], 1'b1);
        chk("t5_late_rdata", log_rdata[base+1], 8'h00);

        // Reset during WAIT with two more commands queued.
        push_cmd(7'h30, 1'b1, 8'h01, NEVER);
        push_cmd(7'h31, 1'b1, 8'h02, NEVER);
        push_cmd(7'h32, 1'b1, 8'h03, NEVER);
        seen = 1'b0;
        for (int i = 0; i < 50 && !seen; i++) begin
            @(negedge clk);
            seen = !eng_rst;
        end
        chk("t6_launched", seen, 1'b1);
        repeat (10) @(posedge clk);
        #2;
        base = log_rdata.size();
        rst_n = 1'b0;
        #1;
        chk("t6_eng_rst", eng_rst, 1'b1);
        chk("t6_rsp_valid", rsp_valid, 1'b0);
        chk("t6_cmd_ready", cmd_ready, 1'b1);
        chk("t6_busy", busy, 1'b0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (150) tick();
        chk("t6_no_rsp", log_rdata.size() - base, 0);
        chk("t6_idle", busy, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, %0d compared / %0d mismatched", n_cmp, n_bad);
        $fatal(1);
    end

endmodule
